scatter_engine: RTL and testbench

Axis-0 row scatter engine, the write-side counterpart of the graph unit's gather: for each entry `k` of an int8 index array, it copies source row `k` into destination row `index[k]` in SRAM0. It supports overwrite mode and saturating int8 accumulate mode (scatter-add). It shares the single-port-pair SRAM0 interface and the cmd/busy/done protocol with the other graph engines, and is dispatched by the graph sequencer.

---
 rtl/graph_isa_pkg.sv | 20 ++
 rtl/scatter_engine.sv | 183 ++++++++++++++++++
 tb/tb_scatter_engine.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/graph_isa_pkg.sv
// Shared definitions for the graph engines: int8 limits and saturating arithmetic.
package graph_isa_pkg;

  localparam logic signed [7:0] I8Max = 8'sh7f;
  localparam logic signed [7:0] I8Min = 8'sh80;

  // Signed int8 add computed at 9 bits, clamped back into int8 range.
  function automatic logic [7:0] sat_add_i8(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] sum;
    sum = $signed({a[7], a}) + $signed({b[7], b});
    if (sum > 9'sd127) begin
      return I8Max;
    end else if (sum < -9'sd128) begin
      return I8Min;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/scatter_engine.sv
// Axis-0 row scatter: copies source row k into destination row index[k] in SRAM0,
// either overwriting or saturating-adding into the destination.
module scatter_engine
  import graph_isa_pkg::*;
#(
  parameter int unsigned SRAM0_AW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [15:0]         cmd_src_base,
  input  logic [15:0]         cmd_idx_base,
  input  logic [15:0]         cmd_dst_base,
  input  logic [15:0]         cmd_num_indices,
  input  logic [15:0]         cmd_row_size,
  input  logic [15:0]         cmd_num_rows,
  input  logic                cmd_accumulate,
  output logic                sram_rd_en,
  output logic [SRAM0_AW-1:0] sram_rd_addr,
  input  logic [7:0]          sram_rd_data,
  output logic                sram_wr_en,
  output logic [SRAM0_AW-1:0] sram_wr_addr,
  output logic [7:0]          sram_wr_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    ScIdle,
    ScRdIdx,
    ScLatchIdx,
    ScSrcRd,
    ScDstRd,
    ScWr,
    ScNextIdx,
    ScDone
  } sc_state_t;

  sc_state_t   state_q, state_d;
  logic [15:0] src_base_q, src_base_d;
  logic [15:0] idx_base_q, idx_base_d;
  logic [15:0] dst_base_q, dst_base_d;
  logic [15:0] num_idx_q, num_idx_d;
  logic [15:0] row_size_q, row_size_d;
  logic [15:0] num_rows_q, num_rows_d;
  logic        accum_q, accum_d;
  logic [15:0] idx_cnt_q, idx_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  index_val_q, index_val_d;
  logic [7:0]  src_byte_q, src_byte_d;

  logic [15:0] idx_addr;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  // Next-state and register update logic for the scatter FSM.
  always_comb begin
    state_d     = state_q;
    src_base_d  = src_base_q;
    idx_base_d  = idx_base_q;
    dst_base_d  = dst_base_q;
    num_idx_d   = num_idx_q;
    row_size_d  = row_size_q;
    num_rows_d  = num_rows_q;
    accum_d     = accum_q;
    idx_cnt_d   = idx_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    index_val_d = index_val_q;
    src_byte_d  = src_byte_q;
    unique case (state_q)
      ScIdle: begin
        if (cmd_valid) begin
          src_base_d = cmd_src_base;
          idx_base_d = cmd_idx_base;
          dst_base_d = cmd_dst_base;
          num_idx_d  = cmd_num_indices;
          row_size_d = cmd_row_size;
          num_rows_d = cmd_num_rows;
          accum_d    = cmd_accumulate;
          idx_cnt_d  = '0;
          state_d    = (cmd_num_indices == 16'd0) ? ScDone : ScRdIdx;
        end
      end
      ScRdIdx: state_d = ScLatchIdx;
      ScLatchIdx: begin
        index_val_d = sram_rd_data;
        byte_cnt_d  = '0;
        // Out-of-bounds rows and empty rows are skipped without touching SRAM.
        if (({8'd0, sram_rd_data} >= num_rows_q) || (row_size_q == 16'd0)) begin
          state_d = ScNextIdx;
        end else begin
          state_d = ScSrcRd;
        end
      end
      ScSrcRd: state_d = accum_q ? ScDstRd : ScWr;
      ScDstRd: begin
        src_byte_d = sram_rd_data;
        state_d    = ScWr;
      end
      ScWr: begin
        byte_cnt_d = byte_cnt_q + 16'd1;
        state_d    = (byte_cnt_q == row_size_q - 16'd1) ? ScNextIdx : ScSrcRd;
      end
      ScNextIdx: begin
        idx_cnt_d = idx_cnt_q + 16'd1;
        state_d   = (idx_cnt_q == num_idx_q - 16'd1) ? ScDone : ScRdIdx;
      end
      ScDone:  state_d = ScIdle;
      default: state_d = ScIdle;
    endcase
  end

  // State and command registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ScIdle;
      src_base_q  <= '0;
      idx_base_q  <= '0;
      dst_base_q  <= '0;
      num_idx_q   <= '0;
      row_size_q  <= '0;
      num_rows_q  <= '0;
      accum_q     <= 1'b0;
      idx_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      index_val_q <= '0;
      src_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_base_q  <= src_base_d;
      idx_base_q  <= idx_base_d;
      dst_base_q  <= dst_base_d;
      num_idx_q   <= num_idx_d;
      row_size_q  <= row_size_d;
      num_rows_q  <= num_rows_d;
      accum_q     <= accum_d;
      idx_cnt_q   <= idx_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      index_val_q <= index_val_d;
      src_byte_q  <= src_byte_d;
    end
  end

  // Row address generation: 16-bit multiply-add with modulo wrap.
  always_comb begin
    idx_addr = idx_base_q + idx_cnt_q;
    src_addr = src_base_q + idx_cnt_q * row_size_q + byte_cnt_q;
    dst_addr = dst_base_q + {8'd0, index_val_q} * row_size_q + byte_cnt_q;
  end

  // Output decode from state and registers only; idle outputs are all zero.
  always_comb begin
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    sram_wr_en   = 1'b0;
    sram_wr_addr = '0;
    sram_wr_data = '0;
    busy         = (state_q != ScIdle);
    done         = (state_q == ScDone);
    unique case (state_q)
      ScRdIdx: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = idx_addr[SRAM0_AW-1:0];
      end
      ScSrcRd: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = src_addr[SRAM0_AW-1:0];
      end
      ScDstRd: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = dst_addr[SRAM0_AW-1:0];
      end
      ScWr: begin
        sram_wr_en   = 1'b1;
        sram_wr_addr = dst_addr[SRAM0_AW-1:0];
        // Read data here is the source byte (overwrite) or the old destination byte.
        sram_wr_data = accum_q ? sat_add_i8(src_byte_q, sram_rd_data) : sram_rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scatter_engine.sv
// Directed bench for scatter_engine with a behavioural single-cycle SRAM model.
module tb_scatter_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_src_base = '0;
  logic [15:0] cmd_idx_base = '0;
  logic [15:0] cmd_dst_base = '0;
  logic [15:0] cmd_num_indices = '0;
  logic [15:0] cmd_row_size = '0;
  logic [15:0] cmd_num_rows = '0;
  logic        cmd_accumulate = 1'b0;
  logic        sram_rd_en;
  logic [15:0] sram_rd_addr;
  logic [7:0]  sram_rd_data = '0;
  logic        sram_wr_en;
  logic [15:0] sram_wr_addr;
  logic [7:0]  sram_wr_data;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [15:0] watch_lo = 16'hffff;
  logic [15:0] watch_hi = 16'h0000;
  int          rd_count = 0;
  int          wr_count = 0;
  int          both_count = 0;
  int          watch_hits = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scatter_engine #(.SRAM0_AW(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_src_base    (cmd_src_base),
    .cmd_idx_base    (cmd_idx_base),
    .cmd_dst_base    (cmd_dst_base),
    .cmd_num_indices (cmd_num_indices),
    .cmd_row_size    (cmd_row_size),
    .cmd_num_rows    (cmd_num_rows),
    .cmd_accumulate  (cmd_accumulate),
    .sram_rd_en      (sram_rd_en),
    .sram_rd_addr    (sram_rd_addr),
    .sram_rd_data    (sram_rd_data),
    .sram_wr_en      (sram_wr_en),
    .sram_wr_addr    (sram_wr_addr),
    .sram_wr_data    (sram_wr_data),
    .busy            (busy),
    .done            (done)
  );

  // SRAM model plus activity counters.
  always @(posedge clk) begin
    if (sram_rd_en) begin
      sram_rd_data <= mem[sram_rd_addr];
      rd_count     <= rd_count + 1;
    end
    if (sram_wr_en) begin
      mem[sram_wr_addr] <= sram_wr_data;
      wr_count          <= wr_count + 1;
      if (sram_wr_addr >= watch_lo && sram_wr_addr <= watch_hi) watch_hits <= watch_hits + 1;
    end
    if (sram_rd_en && sram_wr_en) both_count <= both_count + 1;
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  task automatic poke(input logic [15:0] addr, input logic [7:0] data);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input int len, input logic [7:0] data);
    for (int i = 0; i < len; i++) poke(base + 16'(i), data);
  endtask

  // Issue one command; returns #1 after the accept edge with cmd inputs scrambled.
  task automatic start_cmd(input logic [15:0] src, input logic [15:0] idx,
                           input logic [15:0] dst, input logic [15:0] nidx,
                           input logic [15:0] rsz, input logic [15:0] nrows,
                           input logic acc);
    cmd_src_base    = src;
    cmd_idx_base    = idx;
    cmd_dst_base    = dst;
    cmd_num_indices = nidx;
    cmd_row_size    = rsz;
    cmd_num_rows    = nrows;
    cmd_accumulate  = acc;
    cmd_valid       = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid       = 1'b0;
    cmd_src_base    = 16'hdead;
    cmd_idx_base    = 16'hbeef;
    cmd_dst_base    = 16'hf00d;
    cmd_num_indices = 16'h0007;
    cmd_row_size    = 16'h0009;
    cmd_num_rows    = 16'h00ff;
    cmd_accumulate  = ~acc;
  endtask

  // Cycles counted from the accept edge (=1) to the first cycle with done high; -1 on timeout.
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      if (done) begin
        cycles = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({busy, done, sram_rd_en, sram_wr_en} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, sram_rd_en, sram_wr_en});
    end
    n_cmp++;
    if ({sram_rd_addr, sram_wr_addr, sram_wr_data} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h expected 0", {sram_rd_addr, sram_wr_addr, sram_wr_data});
    end
  endtask

  task automatic test_overwrite;
    int cyc;
    for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 8'(11 + i));
    for (int i = 0; i < 4; i++) poke(16'h0104 + 16'(i), 8'(21 + i));
    poke(16'h0200, 8'd2);
    poke(16'h0201, 8'd0);
    fill(16'h0300, 16, 8'hee);
    start_cmd(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd4, 16'd4, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ovw_busy: got %b expected 1", busy);
    end
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 23) begin
      n_bad++;
      $display("FAIL ovw_latency: got %0d expected 23", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0308 + 16'(i)] !== 8'(11 + i)) begin
        n_bad++;
        $display("FAIL ovw_row2[%0d]: got %0d expected %0d", i, mem[16'h0308 + 16'(i)], 11 + i);
      end
      n_cmp++;
      if (mem[16'h0300 + 16'(i)] !== 8'(21 + i)) begin
        n_bad++;
        $display("FAIL ovw_row0[%0d]: got %0d expected %0d", i, mem[16'h0300 + 16'(i)], 21 + i);
      end
      n_cmp++;
      if (mem[16'h0304 + 16'(i)] !== 8'hee || mem[16'h030c + 16'(i)] !== 8'hee) begin
        n_bad++;
        $display("FAIL ovw_untouched[%0d]: got %h/%h expected ee/ee", i,
                 mem[16'h0304 + 16'(i)], mem[16'h030c + 16'(i)]);
      end
    end
  endtask

  task automatic test_oob;
    int cyc;
    int hits0;
    poke(16'h0210, 8'd5);
    poke(16'h0211, 8'd1);
    fill(16'h0400, 24, 8'hee);
    watch_lo = 16'h0414;
    watch_hi = 16'h0417;
    hits0 = watch_hits;
    start_cmd(16'h0100, 16'h0210, 16'h0400, 16'd2, 16'd4, 16'd4, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (!(sram_rd_en === 1'b1 && sram_rd_addr === 16'h0211)) begin
      n_bad++;
      $display("FAIL oob_skip_cost: got rd_en=%b addr=%h expected 1/0211", sram_rd_en,
               sram_rd_addr);
    end
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 12) begin
      n_bad++;
      $display("FAIL oob_latency: got %0d expected 12 after index 1 start", cyc);
    end
    n_cmp++;
    if (watch_hits - hits0 != 0) begin
      n_bad++;
      $display("FAIL oob_no_write: got %0d writes expected 0", watch_hits - hits0);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0404 + 16'(i)] !== 8'(21 + i)) begin
        n_bad++;
        $display("FAIL oob_row1[%0d]: got %0d expected %0d", i, mem[16'h0404 + 16'(i)], 21 + i);
      end
    end
    n_cmp++;
    if (mem[16'h0400] !== 8'hee || mem[16'h0414] !== 8'hee) begin
      n_bad++;
      $display("FAIL oob_untouched: got %h/%h expected ee/ee", mem[16'h0400], mem[16'h0414]);
    end
  endtask

  task automatic test_accum_sat;
    int cyc;
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h7f;
    exp_v[1] = 8'h80;
    exp_v[2] = 8'hfe;
    poke(16'h0220, 8'd0);
    poke(16'h0130, 8'd50);
    poke(16'h0131, 8'hc4);
    poke(16'h0132, 8'hfb);
    poke(16'h0500, 8'd100);
    poke(16'h0501, 8'h9c);
    poke(16'h0502, 8'd3);
    start_cmd(16'h0130, 16'h0220, 16'h0500, 16'd1, 16'd3, 16'd1, 1'b1);
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 13) begin
      n_bad++;
      $display("FAIL acc_latency: got %0d expected 13", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[16'h0500 + 16'(i)] !== exp_v[i]) begin
        n_bad++;
        $display("FAIL acc_sat[%0d]: got %h expected %h", i, mem[16'h0500 + 16'(i)], exp_v[i]);
      end
    end
  endtask

  task automatic test_duplicate;
    int cyc;
    poke(16'h0230, 8'd1);
    poke(16'h0231, 8'd1);
    poke(16'h0140, 8'd10);
    poke(16'h0141, 8'd20);
    poke(16'h0600, 8'd0);
    poke(16'h0601, 8'd0);
    start_cmd(16'h0140, 16'h0230, 16'h0600, 16'd2, 16'd1, 16'd2, 1'b1);
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 13 || mem[16'h0601] !== 8'd30 || mem[16'h0600] !== 8'd0) begin
      n_bad++;
      $display("FAIL dup_accum: got cyc=%0d row1=%0d row0=%0d expected 13/30/0", cyc,
               mem[16'h0601], mem[16'h0600]);
    end
    poke(16'h0601, 8'd0);
    start_cmd(16'h0140, 16'h0230, 16'h0600, 16'd2, 16'd1, 16'd2, 1'b0);
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 11 || mem[16'h0601] !== 8'd20) begin
      n_bad++;
      $display("FAIL dup_overwrite: got cyc=%0d row1=%0d expected 11/20", cyc, mem[16'h0601]);
    end
  endtask

  task automatic test_zero_indices;
    int cyc;
    int rd0;
    int wr0;
    rd0 = rd_count;
    wr0 = wr_count;
    start_cmd(16'h0100, 16'h0200, 16'h0300, 16'd0, 16'd4, 16'd4, 1'b0);
    wait_done(20, cyc);
    n_cmp++;
    if (cyc != 1 || rd_count != rd0 || wr_count != wr0) begin
      n_bad++;
      $display("FAIL zero_indices: got cyc=%0d rd=%0d wr=%0d expected 1/0/0", cyc,
               rd_count - rd0, wr_count - wr0);
    end
  endtask

  task automatic test_zero_rowsize;
    int cyc;
    int rd0;
    int wr0;
    rd0 = rd_count;
    wr0 = wr_count;
    start_cmd(16'h0100, 16'h0200, 16'h0300, 16'd2, 16'd0, 16'd4, 1'b0);
    wait_done(50, cyc);
    n_cmp++;
    if (cyc != 7 || rd_count - rd0 != 2 || wr_count != wr0) begin
      n_bad++;
      $display("FAIL zero_rowsize: got cyc=%0d rd=%0d wr=%0d expected 7/2/0", cyc,
               rd_count - rd0, wr_count - wr0);
    end
  endtask

  task automatic test_cmd_held;
    int cyc;
    int wr0;
    poke(16'h0250, 8'd0);
    fill(16'h0780, 2, 8'hee);
    wr0 = wr_count;
    cmd_src_base    = 16'h0100;
    cmd_idx_base    = 16'h0250;
    cmd_dst_base    = 16'h0780;
    cmd_num_indices = 16'd1;
    cmd_row_size    = 16'd2;
    cmd_num_rows    = 16'd1;
    cmd_accumulate  = 1'b0;
    cmd_valid       = 1'b1;
    @(posedge clk);
    #1;
    cmd_dst_base = 16'h07f0;
    cyc = -1;
    for (int n = 1; n <= 50; n++) begin
      if (done) begin
        cyc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (cyc != 8) begin
      n_bad++;
      $display("FAIL held_latency: got %0d expected 8", cyc);
    end
    n_cmp++;
    if (wr_count - wr0 != 2 || mem[16'h0780] !== 8'd11 || mem[16'h0781] !== 8'd12) begin
      n_bad++;
      $display("FAIL held_no_restart: got wr=%0d d0=%0d d1=%0d expected 2/11/12",
               wr_count - wr0, mem[16'h0780], mem[16'h0781]);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    poke(16'h0240, 8'd0);
    fill(16'h0700, 4, 8'hee);
    start_cmd(16'h0100, 16'h0240, 16'h0700, 16'd1, 16'd4, 16'd1, 1'b0);
    seen = 0;
    for (int n = 0; n < 50 && seen < 2; n++) begin
      if (sram_wr_en) seen++;
      if (seen < 2) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seen != 2 || {busy, done, sram_rd_en, sram_wr_en} !== 4'b0000 ||
        {sram_rd_addr, sram_wr_addr, sram_wr_data} !== 40'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got seen=%0d ctrl=%b bus=%h expected 2/0000/0", seen,
               {busy, done, sram_rd_en, sram_wr_en}, {sram_rd_addr, sram_wr_addr, sram_wr_data});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (mem[16'h0700] !== 8'd11 || mem[16'h0701] !== 8'hee || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_commit: got d0=%0d d1=%h busy=%b expected 11/ee/0", mem[16'h0700],
               mem[16'h0701], busy);
    end
    @(posedge clk);
    #1;
    start_cmd(16'h0100, 16'h0240, 16'h0700, 16'd1, 16'd4, 16'd1, 1'b0);
    wait_done(100, cyc);
    n_cmp++;
    if (cyc != 12) begin
      n_bad++;
      $display("FAIL rst_mid_rerun_latency: got %0d expected 12", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[16'h0700 + 16'(i)] !== 8'(11 + i)) begin
        n_bad++;
        $display("FAIL rst_mid_rerun[%0d]: got %0d expected %0d", i, mem[16'h0700 + 16'(i)],
                 11 + i);
      end
    end
  endtask

  task automatic test_port_exclusive;
    n_cmp++;
    if (both_count != 0) begin
      n_bad++;
      $display("FAIL rd_wr_exclusive: got %0d overlapping cycles expected 0", both_count);
    end
  endtask

  initial begin
    test_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_overwrite;
    test_oob;
    test_accum_sat;
    test_duplicate;
    test_zero_indices;
    test_zero_rowsize;
    test_cmd_held;
    test_reset_mid;
    test_port_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
